// File: rtl/regfile_mp_pkg.sv
// Shared register-file constants for the decode, hazard and writeback stages.
package regfile_mp_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned ZERO_IDX   = 0;
  localparam int unsigned SP_IDX_DEF = 15;
  localparam logic [63:0] SP_INIT_DEF = 64'h0000_0000_0040_0000;

  // True when addr names the hardwired zero register and that option is enabled.
  function automatic logic is_zero_reg(input int unsigned addr, input int unsigned zero_reg);
    return (zero_reg != 0) && (addr == ZERO_IDX);
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback-facing bus of the multi-port register file.
interface regfile_mp_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NREAD  = 2
);
  logic [NREAD-1:0]        rd_en;
  logic [NREAD*ADDR_W-1:0] rd_addr;
  logic [NREAD*DATA_W-1:0] rd_data;
  logic [NREAD-1:0]        rd_busy;
  logic                    wr_en;
  logic [ADDR_W-1:0]       wr_addr;
  logic [DATA_W-1:0]       wr_data;
  logic                    claim_en;
  logic [ADDR_W-1:0]       claim_addr;
  logic [2**ADDR_W-1:0]    busy_vec;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, claim_en, claim_addr,
    input  rd_data, rd_busy, busy_vec
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, claim_en, claim_addr,
    output rd_data, rd_busy, busy_vec
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, claim sets, write clears.
module regfile_scoreboard
  import regfile_mp_pkg::*;
#(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NREAD    = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic                    claim_en,
  input  logic [ADDR_W-1:0]       claim_addr,
  input  logic [NREAD-1:0]        rd_en,
  input  logic [NREAD*ADDR_W-1:0] rd_addr,
  output logic [2**ADDR_W-1:0]    busy_vec,
  output logic [NREAD-1:0]        rd_busy
);

  localparam int unsigned Depth = 1 << ADDR_W;

  logic [Depth-1:0] busy_q, busy_d;
  logic [NREAD-1:0] rd_busy_q;

  // Clear before set so a same-edge claim (newer producer) wins over the retiring write.
  always_comb begin
    busy_d = busy_q;
    if (wr_en) busy_d[wr_addr] = 1'b0;
    if (claim_en && !is_zero_reg(int'(claim_addr), ZERO_REG)) busy_d[claim_addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Sampled from busy_d so the flag matches read data that may have been bypassed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_busy_q <= '0;
    end else begin
      for (int p = 0; p < NREAD; p++) begin
        if (rd_en[p]) rd_busy_q[p] <= busy_d[rd_addr[p*ADDR_W +: ADDR_W]];
      end
    end
  end

  assign busy_vec = busy_q;
  assign rd_busy  = rd_busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with write bypass and RAW scoreboard.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int unsigned       DATA_W   = DATA_W_DEF,
  parameter int unsigned       ADDR_W   = ADDR_W_DEF,
  parameter int unsigned       NREAD    = 2,
  parameter int unsigned       ZERO_REG = 1,
  parameter int unsigned       BYPASS   = 1,
  parameter int unsigned       SP_IDX   = SP_IDX_DEF,
  parameter logic [DATA_W-1:0] SP_INIT  = DATA_W'(SP_INIT_DEF)
) (
  input logic         clk,
  input logic         rst,
  regfile_mp_if.slave bus
);

  localparam int unsigned Depth = 1 << ADDR_W;

  logic [DATA_W-1:0]       regs_q [Depth];
  logic [NREAD*DATA_W-1:0] rd_d, rd_q;
  logic                    wr_ok;

  assign wr_ok = bus.wr_en && !is_zero_reg(int'(bus.wr_addr), ZERO_REG);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        regs_q[i] <= (i == SP_IDX) ? SP_INIT : '0;
      end
    end else if (wr_ok) begin
      regs_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  for (genvar p = 0; p < NREAD; p++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              hit_zero, hit_byp;

    assign addr     = bus.rd_addr[p*ADDR_W +: ADDR_W];
    assign hit_zero = is_zero_reg(int'(addr), ZERO_REG);
    assign hit_byp  = (BYPASS != 0) && wr_ok && (bus.wr_addr == addr);
    assign rd_d[p*DATA_W +: DATA_W] = hit_zero ? '0 :
                                      hit_byp  ? bus.wr_data : regs_q[addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q <= '0;
    end else begin
      for (int p = 0; p < NREAD; p++) begin
        if (bus.rd_en[p]) rd_q[p*DATA_W +: DATA_W] <= rd_d[p*DATA_W +: DATA_W];
      end
    end
  end

  assign bus.rd_data = rd_q;

  regfile_scoreboard #(
    .ADDR_W  (ADDR_W),
    .NREAD   (NREAD),
    .ZERO_REG(ZERO_REG)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (bus.wr_en),
    .wr_addr   (bus.wr_addr),
    .claim_en  (bus.claim_en),
    .claim_addr(bus.claim_addr),
    .rd_en     (bus.rd_en),
    .rd_addr   (bus.rd_addr),
    .busy_vec  (bus.busy_vec),
    .rd_busy   (bus.rd_busy)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench: default instance (A) and a 4-port 64-bit no-bypass no-zero instance (B).
module tb_regfile_mp;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NREAD(2)) bus_a ();
  regfile_mp_if #(.DATA_W(64), .ADDR_W(4), .NREAD(4)) bus_b ();

  regfile_mp dut_a (
    .clk(clk),
    .rst(rst),
    .bus(bus_a)
  );

  regfile_mp #(
    .DATA_W  (64),
    .ADDR_W  (4),
    .NREAD   (4),
    .ZERO_REG(0),
    .BYPASS  (0),
    .SP_IDX  (15),
    .SP_INIT (64'h0000_0000_0040_0000)
  ) dut_b (
    .clk(clk),
    .rst(rst),
    .bus(bus_b)
  );

  typedef struct {
    int          port;
    logic [63:0] data;
    logic        busy;
    string       name;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   vectors     = 0;
  int   miscompares = 0;

  localparam logic [63:0] SP = 64'h0000_0000_0040_0000;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitors: a read issued on an edge is compared once its registered output settles.
  always @(posedge clk) begin : mon_a
    logic [1:0] en_s;
    logic       rst_s;
    exp_t       e;
    en_s  = bus_a.rd_en;
    rst_s = rst;
    #3;
    if (!rst_s) begin
      for (int p = 0; p < 2; p++) begin
        if (en_s[p]) begin
          if (q_a.size() == 0) begin
            check($sformatf("a port%0d unexpected read", p), 64'(q_a.size()), 64'd1);
          end else begin
            e = q_a.pop_front();
            check($sformatf("%s port", e.name), 64'(p), 64'(e.port));
            check($sformatf("%s data", e.name), 64'(bus_a.rd_data[p*32 +: 32]), e.data);
            check($sformatf("%s busy", e.name), 64'(bus_a.rd_busy[p]), 64'(e.busy));
          end
        end
      end
    end
  end

  always @(posedge clk) begin : mon_b
    logic [3:0] en_s;
    logic       rst_s;
    exp_t       e;
    en_s  = bus_b.rd_en;
    rst_s = rst;
    #3;
    if (!rst_s) begin
      for (int p = 0; p < 4; p++) begin
        if (en_s[p]) begin
          if (q_b.size() == 0) begin
            check($sformatf("b port%0d unexpected read", p), 64'(q_b.size()), 64'd1);
          end else begin
            e = q_b.pop_front();
            check($sformatf("%s port", e.name), 64'(p), 64'(e.port));
            check($sformatf("%s data", e.name), bus_b.rd_data[p*64 +: 64], e.data);
            check($sformatf("%s busy", e.name), 64'(bus_b.rd_busy[p]), 64'(e.busy));
          end
        end
      end
    end
  end

  task automatic idle_inputs();
    bus_a.rd_en    = '0;
    bus_a.wr_en    = 1'b0;
    bus_a.claim_en = 1'b0;
    bus_b.rd_en    = '0;
    bus_b.wr_en    = 1'b0;
    bus_b.claim_en = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic wr_a(input logic [4:0] addr, input logic [31:0] data);
    bus_a.wr_en   = 1'b1;
    bus_a.wr_addr = addr;
    bus_a.wr_data = data;
  endtask

  task automatic claim_a(input logic [4:0] addr);
    bus_a.claim_en   = 1'b1;
    bus_a.claim_addr = addr;
  endtask

  // Issue in ascending port order within one edge; monitors pop in that order.
  task automatic rd_a(input int p, input logic [4:0] addr, input logic [31:0] d,
                      input logic b, input string n);
    bus_a.rd_en[p]            = 1'b1;
    bus_a.rd_addr[p*5 +: 5]   = addr;
    q_a.push_back('{p, 64'(d), b, n});
  endtask

  task automatic wr_b(input logic [3:0] addr, input logic [63:0] data);
    bus_b.wr_en   = 1'b1;
    bus_b.wr_addr = addr;
    bus_b.wr_data = data;
  endtask

  task automatic claim_b(input logic [3:0] addr);
    bus_b.claim_en   = 1'b1;
    bus_b.claim_addr = addr;
  endtask

  task automatic rd_b(input int p, input logic [3:0] addr, input logic [63:0] d,
                      input logic b, input string n);
    bus_b.rd_en[p]          = 1'b1;
    bus_b.rd_addr[p*4 +: 4] = addr;
    q_b.push_back('{p, d, b, n});
  endtask

  initial begin
    idle_inputs();
    bus_a.rd_addr = '0; bus_a.wr_addr = '0; bus_a.wr_data = '0; bus_a.claim_addr = '0;
    bus_b.rd_addr = '0; bus_b.wr_addr = '0; bus_b.wr_data = '0; bus_b.claim_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("a reset busy_vec", 64'(bus_a.busy_vec), 64'd0);

    // Reset mid-operation
    wr_a(5'd4, 32'h0000_AAAA); claim_a(5'd4); tick();
    wr_a(5'd15, 32'h0000_5555); rd_a(0, 5'd4, 32'h0000_AAAA, 1'b1, "a pre-reset reg4"); tick();
    tick();
    check("a busy4 before reset", 64'(bus_a.busy_vec[4]), 64'd1);
    rst = 1'b1;
    #1;
    check("a async reset rd_data", 64'(bus_a.rd_data), 64'd0);
    check("a async reset busy_vec", 64'(bus_a.busy_vec), 64'd0);
    tick();
    rst = 1'b0;
    rd_a(0, 5'd15, 32'h0040_0000, 1'b0, "a reset reg15");
    rd_a(1, 5'd4, 32'h0, 1'b0, "a reset reg4");
    tick();
    check("a busy_vec after reset", 64'(bus_a.busy_vec), 64'd0);

    // Write then read, then hold with rd_en low
    wr_a(5'd7, 32'hDEAD_BEEF); tick();
    rd_a(0, 5'd7, 32'hDEAD_BEEF, 1'b0, "a write-read reg7"); tick();
    bus_a.rd_addr[4:0] = 5'd15;
    wr_a(5'd7, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("a hold cycle %0d", i), 64'(bus_a.rd_data[31:0]), 64'hDEAD_BEEF);
    end

    // Same-edge bypass on both ports
    wr_a(5'd9, 32'h0000_1234);
    rd_a(0, 5'd9, 32'h0000_1234, 1'b0, "a bypass p0");
    rd_a(1, 5'd9, 32'h0000_1234, 1'b0, "a bypass p1");
    tick();

    // Zero register: write, claim and bypass all suppressed
    wr_a(5'd0, 32'hFFFF_FFFF); claim_a(5'd0);
    rd_a(0, 5'd0, 32'h0, 1'b0, "a zero same-edge");
    tick();
    check("a busy0 after claim", 64'(bus_a.busy_vec[0]), 64'd0);
    rd_a(1, 5'd0, 32'h0, 1'b0, "a zero read"); tick();

    // Scoreboard
    claim_a(5'd3); tick();
    check("a busy3 after claim", 64'(bus_a.busy_vec[3]), 64'd1);
    rd_a(1, 5'd3, 32'h0, 1'b1, "a claimed reg3"); tick();
    wr_a(5'd3, 32'h33); claim_a(5'd3); tick();
    check("a busy3 write+claim", 64'(bus_a.busy_vec[3]), 64'd1);
    wr_a(5'd3, 32'h77); rd_a(0, 5'd3, 32'h77, 1'b0, "a write clears busy"); tick();
    check("a busy3 after write", 64'(bus_a.busy_vec[3]), 64'd0);
    claim_a(5'd5); rd_a(0, 5'd5, 32'h0, 1'b1, "a claim same edge"); tick();
    rd_a(1, 5'd3, 32'h77, 1'b0, "a reg3 stored"); tick();
    check("a busy_vec final", 64'(bus_a.busy_vec), 64'h20);

    // Instance B: no bypass, no zero register, four 64-bit ports
    wr_b(4'd9, 64'h1234);
    rd_b(0, 4'd9, 64'h0, 1'b0, "b no-bypass p0");
    rd_b(1, 4'd9, 64'h0, 1'b0, "b no-bypass p1");
    tick();
    rd_b(2, 4'd9, 64'h1234, 1'b0, "b reg9 stored"); tick();
    wr_b(4'd0, 64'hFFFF_FFFF); claim_b(4'd0); tick();
    check("b busy0 after claim", 64'(bus_b.busy_vec[0]), 64'd1);
    rd_b(0, 4'd0, 64'hFFFF_FFFF, 1'b1, "b reg0 writable"); tick();
    wr_b(4'd1, 64'h1111_2222_3333_4444); tick();
    wr_b(4'd2, 64'hAAAA_BBBB_CCCC_DDDD); tick();
    rd_b(0, 4'd1, 64'h1111_2222_3333_4444, 1'b0, "b four-port p0");
    rd_b(1, 4'd2, 64'hAAAA_BBBB_CCCC_DDDD, 1'b0, "b four-port p1");
    rd_b(2, 4'd1, 64'h1111_2222_3333_4444, 1'b0, "b four-port p2");
    rd_b(3, 4'd15, SP, 1'b0, "b four-port p3");
    tick();
    claim_b(4'd6); tick();
    check("b busy6 after claim", 64'(bus_b.busy_vec[6]), 64'd1);
    rst = 1'b1;
    #1;
    check("b reset busy_vec", 64'(bus_b.busy_vec), 64'd0);
    check("b reset rd_data p3", bus_b.rd_data[255:192], 64'd0);
    tick();
    rst = 1'b0;
    wr_b(4'd6, 64'h6666); tick();
    rd_b(3, 4'd6, 64'h6666, 1'b0, "b reg6 after reset"); tick();
    check("b busy_vec final", 64'(bus_b.busy_vec), 64'd0);

    tick();
    tick();
    check("a expectations drained", 64'(q_a.size()), 64'd0);
    check("b expectations drained", 64'(q_b.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
